if_fetch_stage: RTL and testbench

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage.sv | 182 ++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: issues word-aligned fetches and fills the IF/ID register.
// Latency: IF/ID updated one cycle after imem_ack_i; a new request follows that same cycle.
// Backpressure: Stall_i parks an acked word in a one-entry hold buffer; Flush_i drops it and redirects.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        PCWrite_i,
    input  logic        Stall_i,
    input  logic        Flush_i,
    input  logic [31:0] BranchTarget_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        IFID_valid_o,
    output logic [31:0] IFID_pc_o,
    output logic [31:0] IFID_instr_o,
    output logic        FetchBusy_o,
    output logic [15:0] StallCnt_o
);

    // S_WAIT: request on the bus. S_HOLD: acked word parked behind a stall.
    // S_DISCARD: a flushed request is still in flight; its ack must be swallowed.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;

    logic        hold_vld_q, hold_vld_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;

    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        redirect;
    logic [31:0] pc_adv;
    logic [31:0] target_aligned;

    // pc + 4 wraps naturally in 32 bits; PCWrite_i=0 refetches the same word.
    assign pc_adv         = PCWrite_i ? (pc_q + 32'd4) : pc_q;
    assign target_aligned = BranchTarget_i & 32'hFFFF_FFFC;

    // Next-state and datapath: flush beats stall beats normal flow in every active state.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        hold_vld_d   = hold_vld_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        redirect     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Flush, stall and acks are all meaningless before fetching starts.
                if (start_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (Flush_i) begin
                    redirect = 1'b1;
                    // An unanswered request is still owed an ack; swallow it first.
                    state_d  = imem_ack_i ? S_WAIT : S_DISCARD;
                end else if (imem_ack_i) begin
                    if (Stall_i) begin
                        hold_vld_d   = 1'b1;
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem_data_i;
                        state_d      = S_HOLD;
                    end else begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = pc_q;
                        ifid_instr_d = imem_data_i;
                        pc_d         = pc_adv;
                    end
                end
            end

            S_HOLD: begin
                // No request is outstanding here, so any ack seen is spurious.
                if (Flush_i) begin
                    redirect = 1'b1;
                    state_d  = S_WAIT;
                end else if (!Stall_i) begin
                    ifid_valid_d = hold_vld_q;
                    ifid_pc_d    = hold_pc_q;
                    ifid_instr_d = hold_instr_q;
                    hold_vld_d   = 1'b0;
                    pc_d         = pc_adv;
                    state_d      = S_WAIT;
                end
            end

            S_DISCARD: begin
                if (Flush_i) begin
                    redirect = 1'b1;
                end
                // The stale ack closes the discard window; the redirected fetch follows.
                if (imem_ack_i) begin
                    state_d = S_WAIT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redirect) begin
            pc_d         = target_aligned;
            ifid_valid_d = 1'b0;
            ifid_pc_d    = 32'h0000_0000;
            ifid_instr_d = NOP_INSTR;
            hold_vld_d   = 1'b0;
            hold_pc_d    = 32'h0000_0000;
            hold_instr_d = NOP_INSTR;
        end
    end

    // Stall cycle counter: counts only once fetching has started, and sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q != S_IDLE) && Stall_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State and pipeline registers; reset abandons any in-flight request immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_instr_q <= NOP_INSTR;
            hold_vld_q   <= 1'b0;
            hold_pc_q    <= 32'h0000_0000;
            hold_instr_q <= NOP_INSTR;
            stall_cnt_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            hold_vld_q   <= hold_vld_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // The request is raised only in S_WAIT; pc_q cannot move there until the ack or a flush,
    // so the address is stable for the whole request. A discarded request is already owned
    // by the memory, so it is not re-presented while waiting for its ack.
    assign imem_req_o   = (state_q == S_WAIT);
    assign imem_addr_o  = pc_q;
    assign FetchBusy_o  = ((state_q == S_WAIT) || (state_q == S_DISCARD)) && !imem_ack_i;

    assign IFID_valid_o = ifid_valid_q;
    assign IFID_pc_o    = ifid_pc_q;
    assign IFID_instr_o = ifid_instr_q;
    assign StallCnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized traffic against a reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units after it.
// The reference model tracks fetch progress with plain flags and integers.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, PCWrite_i, Stall_i, Flush_i, imem_ack_i;
    logic [31:0] BranchTarget_i, imem_data_i;
    logic        imem_req_o, IFID_valid_o, FetchBusy_o;
    logic [31:0] imem_addr_o, IFID_pc_o, IFID_instr_o;
    logic [15:0] StallCnt_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    bit          m_started, m_buf_full, m_drop, m_valid;
    logic [31:0] m_pc, m_ifpc, m_instr, m_buf_pc, m_buf_instr;
    int          m_cnt;

    if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .PCWrite_i      (PCWrite_i),
        .Stall_i        (Stall_i),
        .Flush_i        (Flush_i),
        .BranchTarget_i (BranchTarget_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_data_i    (imem_data_i),
        .IFID_valid_o   (IFID_valid_o),
        .IFID_pc_o      (IFID_pc_o),
        .IFID_instr_o   (IFID_instr_o),
        .FetchBusy_o    (FetchBusy_o),
        .StallCnt_o     (StallCnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started  = 0;
        m_buf_full = 0;
        m_drop     = 0;
        m_valid    = 0;
        m_pc       = RST_PC;
        m_ifpc     = 32'h0;
        m_instr    = NOP;
        m_cnt      = 0;
    endtask

    // One clock of fetch behaviour, written from the stage's rules.
    task automatic model_step(input bit st, input bit pcw, input bit stl, input bit fl,
                              input logic [31:0] tgt, input bit ack, input logic [31:0] dat);
        bit fetching;
        if (!m_started) begin
            if (st) m_started = 1;
        end else begin
            fetching = !m_buf_full && !m_drop;
            if (stl && m_cnt < 65535) m_cnt++;
            if (fl) begin
                m_drop     = (fetching || m_drop) && !ack;
                m_buf_full = 0;
                m_valid    = 0;
                m_ifpc     = 32'h0;
                m_instr    = NOP;
                m_pc       = {tgt[31:2], 2'b00};
            end else if (m_drop) begin
                if (ack) m_drop = 0;
            end else if (m_buf_full) begin
                if (!stl) begin
                    m_valid    = 1;
                    m_ifpc     = m_buf_pc;
                    m_instr    = m_buf_instr;
                    m_buf_full = 0;
                    if (pcw) m_pc = m_pc + 32'd4;
                end
            end else if (ack) begin
                if (stl) begin
                    m_buf_full  = 1;
                    m_buf_pc    = m_pc;
                    m_buf_instr = dat;
                end else begin
                    m_valid = 1;
                    m_ifpc  = m_pc;
                    m_instr = dat;
                    if (pcw) m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit exp_req;
        exp_req = m_started && !m_buf_full && !m_drop;
        check_val("req", 32'(imem_req_o), 32'(exp_req));
        if (exp_req) check_val("addr", imem_addr_o, m_pc);
        check_val("busy", 32'(FetchBusy_o), 32'((exp_req || m_drop) && !imem_ack_i));
        check_val("ifid_valid", 32'(IFID_valid_o), 32'(m_valid));
        check_val("ifid_pc", IFID_pc_o, m_ifpc);
        check_val("ifid_instr", IFID_instr_o, m_instr);
        check_val("stall_cnt", 32'(StallCnt_o), 32'(m_cnt));
    endtask

    // Drive one cycle of inputs, optionally compare, advance model and clock.
    task automatic cyc(input bit st, input bit pcw, input bit stl, input bit fl,
                       input logic [31:0] tgt, input bit ack, input logic [31:0] dat,
                       input bit chk);
        start_i        = st;
        PCWrite_i      = pcw;
        Stall_i        = stl;
        Flush_i        = fl;
        BranchTarget_i = tgt;
        imem_ack_i     = ack;
        imem_data_i    = dat;
        #2;
        if (chk) compare_all();
        model_step(st, pcw, stl, fl, tgt, ack, dat);
        @(posedge clk_i);
        #1;
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        rst_i = 1'b0;
        #1;
        model_reset();
        check_val("rst_req", 32'(imem_req_o), 32'h0);
        check_val("rst_valid", 32'(IFID_valid_o), 32'h0);
        check_val("rst_instr", IFID_instr_o, NOP);
        compare_all();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0;
        start_i = 0; PCWrite_i = 0; Stall_i = 0; Flush_i = 0;
        BranchTarget_i = 0; imem_ack_i = 0; imem_data_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        compare_all();
        check_val("reset_addr", imem_addr_o, RST_PC);
        rst_i = 1'b1;

        // Basic fetch, ack two cycles after each request.
        cyc(1, 1, 0, 0, 0, 0, 0, 1);
        check_val("first_addr", imem_addr_o, 32'h0);
        check_val("first_req", 32'(imem_req_o), 32'h1);
        cyc(1, 1, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 1, 32'h0050_0093, 1);
        check_val("ifid0_pc", IFID_pc_o, 32'h0);
        check_val("ifid0_instr", IFID_instr_o, 32'h0050_0093);
        check_val("ifid0_valid", 32'(IFID_valid_o), 32'h1);
        check_val("addr4", imem_addr_o, 32'h4);
        cyc(1, 1, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 1, 32'h0010_0113, 1);
        check_val("ifid1_pc", IFID_pc_o, 32'h4);
        check_val("addr8", imem_addr_o, 32'h8);

        // Ack under stall goes to hold; spurious ack in hold is ignored.
        cyc(1, 1, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 1, 0, 0, 1, 32'h0020_0193, 1);
        check_val("hold_req", 32'(imem_req_o), 32'h0);
        check_val("hold_ifid_pc", IFID_pc_o, 32'h4);
        cyc(1, 0, 1, 0, 0, 1, 32'h1111_1111, 1);
        cyc(1, 0, 1, 0, 0, 0, 0, 1);
        check_val("stall_cnt3", 32'(StallCnt_o), 32'd3);
        check_val("hold_ifid_pc2", IFID_pc_o, 32'h4);
        cyc(1, 1, 0, 0, 0, 0, 0, 1);
        check_val("release_pc", IFID_pc_o, 32'h8);
        check_val("release_instr", IFID_instr_o, 32'h0020_0193);
        check_val("addrC", imem_addr_o, 32'hC);

        // Flush with request outstanding: the late ack is dropped.
        cyc(1, 1, 0, 0, 0, 1, 32'h0030_0213, 1);
        check_val("addr10", imem_addr_o, 32'h10);
        cyc(1, 1, 0, 1, 32'h40, 0, 0, 1);
        check_val("discard_req", 32'(imem_req_o), 32'h0);
        cyc(1, 1, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
        check_val("drop_instr", IFID_instr_o, NOP);
        check_val("drop_valid", 32'(IFID_valid_o), 32'h0);
        check_val("addr40", imem_addr_o, 32'h40);
        check_val("req40", 32'(imem_req_o), 32'h1);

        // Flush and stall together with ack: flush wins.
        cyc(1, 1, 1, 1, 32'h80, 1, 32'hCAFE_F00D, 1);
        check_val("fs_addr", imem_addr_o, 32'h80);
        check_val("fs_req", 32'(imem_req_o), 32'h1);
        check_val("fs_instr", IFID_instr_o, NOP);

        // Misaligned target is aligned; pc wraps past the top of memory.
        cyc(1, 1, 0, 1, 32'hFFFF_FFFF, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 1, 32'h0BAD_0BAD, 1);
        check_val("top_addr", imem_addr_o, 32'hFFFF_FFFC);
        cyc(1, 1, 0, 0, 0, 1, 32'h0000_0513, 1);
        check_val("wrap_addr", imem_addr_o, 32'h0);
        check_val("wrap_ifid_pc", IFID_pc_o, 32'hFFFF_FFFC);

        // Reset while busy; a late ack before start must do nothing.
        cyc(1, 1, 0, 0, 0, 0, 0, 1);
        check_val("busy_before_rst", 32'(FetchBusy_o), 32'h1);
        do_reset();
        cyc(0, 1, 0, 0, 0, 1, 32'h1234_5678, 1);
        check_val("late_ack_valid", 32'(IFID_valid_o), 32'h0);
        check_val("late_ack_pc", imem_addr_o, RST_PC);
        cyc(0, 1, 1, 1, 32'h100, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        check_val("no_req_idle", 32'(imem_req_o), 32'h0);
        check_val("idle_cnt", 32'(StallCnt_o), 32'h0);

        // Randomized traffic, including spurious acks and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            if ($urandom_range(0, 499) == 0) do_reset();
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0, tgt, $urandom_range(0, 2) == 0, $urandom, 1);
        end

        // Stall counter saturation.
        do_reset();
        cyc(1, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 65540; i++) cyc(1, 1, 1, 0, 0, 0, 0, 0);
        check_val("cnt_sat", 32'(StallCnt_o), 32'h0000_FFFF);
        cyc(1, 1, 1, 0, 0, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 1, 32'h0000_0033, 1);
        cyc(1, 1, 1, 0, 0, 0, 0, 1);
        check_val("cnt_sat_hold", 32'(StallCnt_o), 32'h0000_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
